obi_mem_arbiter: RTL and testbench
==================================

Name: obi_mem_arbiter

Overview:
- Shares one single-port synchronous RAM between the core instruction and data OBI ports.
- Sits between the cv32e40p OBI master ports and the RAM macro. It is the native-bus alternative to routing both masters through the AXI crossbar into the AXI memory slave.
- Arbitrates requests each cycle and tracks in-flight accesses through a fixed-latency response pipeline. Returns each rvalid/rdata to the port that issued the request.

Parameters:
- ADDR_WIDTH, 32, address width of both ports and the RAM.
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 bits.
- MEM_LATENCY, 1, cycles from an accepted RAM request to valid mem_rdata_i; legal range 1..4.
- MAX_STALL, 4, maximum consecutive conflict cycles data may win before instr is forced through; legal range 1..15.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- instr_req_i  in  1  instruction fetch request.
- instr_addr_i  in  ADDR_WIDTH  fetch address.
- instr_gnt_o  out  1  fetch request accepted this cycle.
- instr_rvalid_o  out  1  fetch data valid.
- instr_rdata_o  out  DATA_WIDTH  fetch data.
- data_req_i  in  1  load/store request.
- data_we_i  in  1  1 = store.
- data_be_i  in  DATA_WIDTH/8  byte enables.
- data_addr_i  in  ADDR_WIDTH  load/store address.
- data_wdata_i  in  DATA_WIDTH  store data.
- data_gnt_o  out  1  load/store accepted this cycle.
- data_rvalid_o  out  1  load data valid, or store completion.
- data_rdata_o  out  DATA_WIDTH  load data.
- mem_req_o  out  1  RAM access strobe.
- mem_we_o  out  1  RAM write enable.
- mem_be_o  out  DATA_WIDTH/8  RAM byte enables.
- mem_addr_o  out  ADDR_WIDTH  RAM address.
- mem_wdata_o  out  DATA_WIDTH  RAM write data.
- mem_rdata_i  in  DATA_WIDTH  RAM read data, valid MEM_LATENCY cycles after mem_req_o.

Behaviour:
- Reset values:
  - All gnt/rvalid/mem_req_o/mem_we_o are 0.
  - rdata outputs and mem_* buses are 0.
  - Owner pipeline is empty; stall counter is 0; last winner is INSTR.
- Grant is combinational in the request cycle. At most one of instr_gnt_o and data_gnt_o is high per cycle. mem_req_o equals (instr_gnt_o | data_gnt_o).
- The mem_* bus is muxed combinationally from the winning port. When there is no winner, mem_we_o and mem_be_o are 0.
- Instr grants force mem_we_o=0 and mem_be_o to all ones.
- Arbitration per cycle:
  - Only one port requesting: that port wins.
  - Both requesting (conflict): data wins, unless stall_cnt == MAX_STALL, in which case instr wins.
  - stall_cnt increments on each conflict cycle that data wins, saturating at MAX_STALL.
  - stall_cnt resets to 0 on any instr grant, and on any cycle without a conflict.
- Response routing:
  - Owner shift register is MEM_LATENCY stages deep. Each entry is {valid, is_data}.
  - Stage 0 is loaded with {mem_req_o, data_gnt_o}.
  - The final stage drives rvalid: instr_rvalid_o = valid & ~is_data; data_rvalid_o = valid & is_data.
  - Both rdata outputs take mem_rdata_i in that cycle when their rvalid is high, otherwise 0.
- Stores also produce data_rvalid_o after exactly MEM_LATENCY cycles; data_rdata_o is don't-care (RAM value passed through).
- The arbiter is fully pipelined: a new grant is possible every cycle, and MEM_LATENCY responses may be in flight.
- Response order equals grant order. Each port receives exactly one rvalid per gnt.
- The arbiter never stalls on the response side. OBI masters must accept rvalid unconditionally.
- Requests held without grant keep their address/data stable; the arbiter does not check this.
- Reset asserted mid-operation: in-flight responses are discarded (pipeline cleared), no rvalid is emitted after reset, and stall_cnt returns to 0.
- MEM_LATENCY out of range: elaboration-time error via assertion.

Decomposition:
- Package obi_arb_pkg:
  - owner_e enum (OWNER_INSTR, OWNER_DATA).
  - owner_entry_t struct {valid, owner}.
  - Constants MAX_MEM_LATENCY=4 and MAX_STALL_LIMIT=15.
- One sub-module, obi_resp_pipe: a parameterised MEM_LATENCY-deep shift register of owner_entry_t with async clear.
- Arbitration and muxing stay in the top module.

Test Plan:
- Single instr fetch, addr 0x100, RAM word 0xDEADBEEF, MEM_LATENCY=1 -> instr_gnt_o same cycle; instr_rvalid_o one cycle later with 0xDEADBEEF; data_rvalid_o stays 0.
- Store then load at 0x200, wdata 0x12345678, be 4'b0011 -> mem_we_o=1 with be 0011 on the store; the following load returns 0x????5678 with the upper half unchanged.
- Both ports request continuously, MAX_STALL=4 -> grant pattern D,D,D,D,I repeating; instr receives exactly one rvalid per 5 cycles.
- Back-to-back alternating grants with MEM_LATENCY=3 -> rvalids appear 3 cycles after each grant on the correct port, in order, with no gaps or duplicates.
- Reset pulsed while 2 responses are in flight -> no rvalid after reset deassertion; the next grant is served normally.
- Stall counter reset: 3 conflict cycles, then 1 idle cycle, then a conflict -> data wins (counter cleared by the non-conflict cycle).

Source files
------------

// File: rtl/obi_arb_pkg.sv
// Shared types and limits for the OBI instruction/data memory arbiter.
// The owner tag records which port a pending RAM response belongs to.
package obi_arb_pkg;

  localparam int MAX_MEM_LATENCY = 4;
  localparam int MAX_STALL_LIMIT = 15;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } owner_entry_t;

endpackage

// File: rtl/obi_resp_pipe.sv
// Fixed-depth shift register of owner tags, one stage per RAM latency cycle.
// Reset drops every tag so no response is routed after reset.
module obi_resp_pipe
  import obi_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  owner_entry_t load_entry,
  output owner_entry_t tail_entry
);

  localparam owner_entry_t EMPTY_ENTRY = '{valid: 1'b0, owner: OWNER_INSTR};

  owner_entry_t stage_r [DEPTH];

  // Advance owner tags by one stage each cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= EMPTY_ENTRY;
      end
    end else begin
      stage_r[0] <= load_entry;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign tail_entry = stage_r[DEPTH-1];

endmodule

// File: rtl/obi_mem_arbiter.sv
// Shares one single-port RAM between the instruction and data OBI ports,
// routing each fixed-latency response back to the port that was granted.
module obi_mem_arbiter
  import obi_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_STALL   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int         BE_WIDTH  = DATA_WIDTH / 8;
  localparam logic [3:0] STALL_MAX = 4'(MAX_STALL);

  if (MEM_LATENCY < 1 || MEM_LATENCY > MAX_MEM_LATENCY) begin : g_bad_latency
    $error("obi_mem_arbiter: MEM_LATENCY must be within 1..4");
  end
  if (MAX_STALL < 1 || MAX_STALL > MAX_STALL_LIMIT) begin : g_bad_stall
    $error("obi_mem_arbiter: MAX_STALL must be within 1..15");
  end

  logic         conflict_s;
  logic         instr_win_s;
  logic         data_win_s;
  logic [3:0]   stall_cnt_r;
  logic [3:0]   stall_cnt_nxt_s;
  owner_entry_t issue_s;
  owner_entry_t retire_s;

  assign conflict_s = instr_req_i & data_req_i;

  // Data wins conflicts until instr has been starved MAX_STALL times in a row.
  always_comb begin
    instr_win_s = 1'b0;
    data_win_s  = 1'b0;
    if (conflict_s) begin
      if (stall_cnt_r == STALL_MAX) begin
        instr_win_s = 1'b1;
      end else begin
        data_win_s = 1'b1;
      end
    end else if (instr_req_i) begin
      instr_win_s = 1'b1;
    end else if (data_req_i) begin
      data_win_s = 1'b1;
    end else begin
      instr_win_s = 1'b0;
      data_win_s  = 1'b0;
    end
  end

  // Count consecutive conflicts lost by instr; anything else clears the count.
  always_comb begin
    stall_cnt_nxt_s = 4'd0;
    if (conflict_s && data_win_s) begin
      stall_cnt_nxt_s = (stall_cnt_r == STALL_MAX) ? stall_cnt_r : stall_cnt_r + 4'd1;
    end else begin
      stall_cnt_nxt_s = 4'd0;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_r <= 4'd0;
    end else begin
      stall_cnt_r <= stall_cnt_nxt_s;
    end
  end

  assign instr_gnt_o = instr_win_s;
  assign data_gnt_o  = data_win_s;
  assign mem_req_o   = instr_win_s | data_win_s;

  // Steer the winning port onto the RAM bus; fetches are always full-word reads.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = {BE_WIDTH{1'b0}};
    mem_addr_o  = {ADDR_WIDTH{1'b0}};
    mem_wdata_o = {DATA_WIDTH{1'b0}};
    if (data_win_s) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end else if (instr_win_s) begin
      mem_be_o   = {BE_WIDTH{1'b1}};
      mem_addr_o = instr_addr_i;
    end else begin
      mem_we_o = 1'b0;
    end
  end

  assign issue_s.valid = mem_req_o;
  assign issue_s.owner = data_win_s ? OWNER_DATA : OWNER_INSTR;

  obi_resp_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_resp_pipe (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_entry (issue_s),
    .tail_entry (retire_s)
  );

  // Hand the RAM read data to whichever port owns the retiring slot.
  always_comb begin
    instr_rvalid_o = 1'b0;
    data_rvalid_o  = 1'b0;
    instr_rdata_o  = {DATA_WIDTH{1'b0}};
    data_rdata_o   = {DATA_WIDTH{1'b0}};
    if (retire_s.valid) begin
      case (retire_s.owner)
        OWNER_INSTR: begin
          instr_rvalid_o = 1'b1;
          instr_rdata_o  = mem_rdata_i;
        end
        OWNER_DATA: begin
          data_rvalid_o = 1'b1;
          data_rdata_o  = mem_rdata_i;
        end
        default: begin
          instr_rvalid_o = 1'b0;
          data_rvalid_o  = 1'b0;
        end
      endcase
    end else begin
      instr_rvalid_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Drives one stimulus stream into two arbiters (MEM_LATENCY 1 and 3), each
// with its own RAM model, and scoreboards grants, bus muxing and responses.
module tb_obi_mem_arbiter;

  localparam int NI        = 2;
  localparam int MAX_STALL = 4;
  localparam int W_NONE    = 0;
  localparam int W_INSTR   = 1;
  localparam int W_DATA    = 2;

  typedef struct {
    bit          ireq;
    logic [31:0] iaddr;
    bit          dreq;
    bit          dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [31:0] wdata;
    int          exp_w;
    bit          exp_we;
    logic [3:0]  exp_be;
  } vec_t;

  typedef struct {
    bit          is_data;
    bit          chk_data;
    logic [31:0] data;
    int          due;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        instr_req, data_req, data_we;
  logic [31:0] instr_addr, data_addr, data_wdata;
  logic [3:0]  data_be;

  logic        instr_gnt [NI], instr_rvalid [NI], data_gnt [NI], data_rvalid [NI];
  logic        mem_req [NI], mem_we [NI];
  logic [3:0]  mem_be [NI];
  logic [31:0] instr_rdata [NI], data_rdata [NI], mem_addr [NI], mem_wdata [NI], mem_rdata [NI];

  int    checks = 0;
  int    errors = 0;
  bit    chk_en = 1'b0;
  resp_t sb0 [$];
  resp_t sb1 [$];
  logic [31:0] ref_mem [256];
  vec_t  vecs [$];

  function automatic logic [31:0] init_word(int i);
    return (i == 64) ? 32'hDEADBEEF : (32'hCAFE0000 | 32'(i));
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] ram [256];
    logic [31:0] rd_pipe [LAT];

    initial for (int i = 0; i < 256; i++) ram[i] <= init_word(i);

    always @(posedge clk) begin
      if (mem_req[g]) begin
        rd_pipe[0] <= ram[mem_addr[g][9:2]];
        if (mem_we[g]) ram[mem_addr[g][9:2]] <= merge(ram[mem_addr[g][9:2]], mem_wdata[g], mem_be[g]);
      end else begin
        rd_pipe[0] <= 32'hFFFFFFFF;
      end
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata[g] = rd_pipe[LAT-1];

    obi_mem_arbiter #(
      .ADDR_WIDTH (32), .DATA_WIDTH (32), .MEM_LATENCY (LAT), .MAX_STALL (MAX_STALL)
    ) u_dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .instr_req_i    (instr_req),
      .instr_addr_i   (instr_addr),
      .instr_gnt_o    (instr_gnt[g]),
      .instr_rvalid_o (instr_rvalid[g]),
      .instr_rdata_o  (instr_rdata[g]),
      .data_req_i     (data_req),
      .data_we_i      (data_we),
      .data_be_i      (data_be),
      .data_addr_i    (data_addr),
      .data_wdata_i   (data_wdata),
      .data_gnt_o     (data_gnt[g]),
      .data_rvalid_o  (data_rvalid[g]),
      .data_rdata_o   (data_rdata[g]),
      .mem_req_o      (mem_req[g]),
      .mem_we_o       (mem_we[g]),
      .mem_be_o       (mem_be[g]),
      .mem_addr_o     (mem_addr[g]),
      .mem_wdata_o    (mem_wdata[g]),
      .mem_rdata_i    (mem_rdata[g])
    );
  end

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[lat%0d] @cyc %0d: got %h, expected %h", name, (g == 0) ? 1 : 3, cyc, act, exp);
    end
  endtask

  task automatic check_resp(input int g, input bit have, input resp_t h);
    bit eiv, edv;
    eiv = have && !h.is_data;
    edv = have && h.is_data;
    chk("instr_rvalid", g, 32'(instr_rvalid[g]), 32'(eiv));
    chk("data_rvalid", g, 32'(data_rvalid[g]), 32'(edv));
    if (eiv) chk("instr_rdata", g, instr_rdata[g], h.data);
    else     chk("instr_rdata_idle", g, instr_rdata[g], 32'd0);
    if (!edv)           chk("data_rdata_idle", g, data_rdata[g], 32'd0);
    else if (h.chk_data) chk("data_rdata", g, data_rdata[g], h.data);
  endtask

  // Response scoreboard: the head entry must retire exactly on its due cycle.
  always @(negedge clk) begin
    resp_t h;
    bit    have;
    if (chk_en) begin
      h = '{default: 0};
      have = (sb0.size() > 0) && (sb0[0].due == cyc);
      if (have) h = sb0.pop_front();
      check_resp(0, have, h);
      h = '{default: 0};
      have = (sb1.size() > 0) && (sb1[0].due == cyc);
      if (have) h = sb1.pop_front();
      check_resp(1, have, h);
    end
  end

  function automatic vec_t vrow(bit ireq, logic [31:0] iaddr, bit dreq, bit dwe, logic [3:0] dbe,
                                logic [31:0] daddr, logic [31:0] wdata, int exp_w, bit exp_we,
                                logic [3:0] exp_be);
    vec_t v;
    v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe; v.dbe = dbe;
    v.daddr = daddr; v.wdata = wdata; v.exp_w = exp_w; v.exp_we = exp_we; v.exp_be = exp_be;
    return v;
  endfunction

  task automatic set_idle();
    instr_req = 1'b0; instr_addr = 32'd0; data_req = 1'b0; data_we = 1'b0;
    data_be = 4'd0; data_addr = 32'd0; data_wdata = 32'd0;
  endtask

  task automatic drive(input vec_t v);
    resp_t r;
    logic [31:0] exp_addr;
    @(negedge clk);
    instr_req = v.ireq; instr_addr = v.iaddr; data_req = v.dreq; data_we = v.dwe;
    data_be = v.dbe; data_addr = v.daddr; data_wdata = v.wdata;
    #1;
    exp_addr = (v.exp_w == W_DATA) ? v.daddr : (v.exp_w == W_INSTR) ? v.iaddr : 32'd0;
    for (int g = 0; g < NI; g++) begin
      chk("instr_gnt", g, 32'(instr_gnt[g]), 32'(v.exp_w == W_INSTR));
      chk("data_gnt", g, 32'(data_gnt[g]), 32'(v.exp_w == W_DATA));
      chk("mem_req", g, 32'(mem_req[g]), 32'(v.exp_w != W_NONE));
      chk("mem_we", g, 32'(mem_we[g]), 32'(v.exp_we));
      chk("mem_be", g, 32'(mem_be[g]), 32'(v.exp_be));
      chk("mem_addr", g, mem_addr[g], exp_addr);
      if (v.exp_w == W_DATA && v.dwe) chk("mem_wdata", g, mem_wdata[g], v.wdata);
    end
    if (v.exp_w != W_NONE) begin
      r.is_data  = (v.exp_w == W_DATA);
      r.chk_data = !(r.is_data && v.dwe);
      r.data     = ref_mem[r.is_data ? v.daddr[9:2] : v.iaddr[9:2]];
      if (r.is_data && v.dwe) ref_mem[v.daddr[9:2]] = merge(ref_mem[v.daddr[9:2]], v.wdata, v.dbe);
      r.due = cyc + 1; sb0.push_back(r);
      r.due = cyc + 3; sb1.push_back(r);
    end
  endtask

  initial begin
    vec_t idle_v, conf_v;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    idle_v = vrow(1'b0, 32'd0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, W_NONE, 1'b0, 4'h0);

    // Vector table, applied from reset with the stall counter at 0.
    vecs.push_back(vrow(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, W_INSTR, 1'b0, 4'hF));
    vecs.push_back(idle_v);
    vecs.push_back(vrow(1'b0, 32'd0, 1'b1, 1'b1, 4'h3, 32'h200, 32'h12345678, W_DATA, 1'b1, 4'h3));
    vecs.push_back(vrow(1'b0, 32'd0, 1'b1, 1'b0, 4'hF, 32'h200, 32'd0, W_DATA, 1'b0, 4'hF));
    for (int k = 0; k < 10; k++)
      vecs.push_back(vrow(1'b1, 32'h140 + 32'(4*k), 1'b1, 1'b0, 4'hF, 32'h300 + 32'(4*k), 32'd0,
                          (k % 5 == 4) ? W_INSTR : W_DATA, 1'b0, 4'hF));
    for (int k = 0; k < 3; k++)
      vecs.push_back(vrow(1'b1, 32'h1A0, 1'b1, 1'b0, 4'hF, 32'h340, 32'd0, W_DATA, 1'b0, 4'hF));
    vecs.push_back(idle_v);
    for (int k = 0; k < 5; k++)
      vecs.push_back(vrow(1'b1, 32'h1B0, 1'b1, 1'b0, 4'hF, 32'h350 + 32'(4*k), 32'd0,
                          (k == 4) ? W_INSTR : W_DATA, 1'b0, 4'hF));

    set_idle();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      chk("rst_instr_gnt", g, 32'(instr_gnt[g]), 32'd0);
      chk("rst_data_gnt", g, 32'(data_gnt[g]), 32'd0);
      chk("rst_instr_rvalid", g, 32'(instr_rvalid[g]), 32'd0);
      chk("rst_data_rvalid", g, 32'(data_rvalid[g]), 32'd0);
      chk("rst_mem_req", g, 32'(mem_req[g]), 32'd0);
      chk("rst_mem_we", g, 32'(mem_we[g]), 32'd0);
      chk("rst_mem_be", g, 32'(mem_be[g]), 32'd0);
      chk("rst_mem_addr", g, mem_addr[g], 32'd0);
      chk("rst_instr_rdata", g, instr_rdata[g], 32'd0);
      chk("rst_data_rdata", g, data_rdata[g], 32'd0);
    end
    rst_n = 1'b1;
    chk_en = 1'b1;

    foreach (vecs[i]) drive(vecs[i]);

    // Alternating single-port grants: responses must come back in grant order.
    drive(vrow(1'b1, 32'h180, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, W_INSTR, 1'b0, 4'hF));
    drive(vrow(1'b0, 32'd0, 1'b1, 1'b1, 4'hF, 32'h3F0, 32'hA5A5A5A5, W_DATA, 1'b1, 4'hF));
    drive(vrow(1'b1, 32'h188, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, W_INSTR, 1'b0, 4'hF));
    drive(vrow(1'b0, 32'd0, 1'b1, 1'b0, 4'hF, 32'h3F0, 32'd0, W_DATA, 1'b0, 4'hF));
    drive(vrow(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, W_INSTR, 1'b0, 4'hF));
    drive(vrow(1'b0, 32'd0, 1'b1, 1'b0, 4'hF, 32'h200, 32'd0, W_DATA, 1'b0, 4'hF));

    // Saturate the stall counter with loads in flight, then reset mid-operation.
    conf_v = vrow(1'b1, 32'h1C0, 1'b1, 1'b0, 4'hF, 32'h360, 32'd0, W_DATA, 1'b0, 4'hF);
    repeat (4) drive(conf_v);
    @(negedge clk);
    set_idle();
    #2;
    rst_n = 1'b0;
    sb0.delete();
    sb1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) drive(idle_v);
    drive(conf_v);
    drive(vrow(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, W_INSTR, 1'b0, 4'hF));
    repeat (6) drive(idle_v);

    chk("sb_drain", 0, 32'(sb0.size()), 32'd0);
    chk("sb_drain", 1, 32'(sb1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
